// File: rtl/tpu_wb_master.sv
// tpu_wb_master
// Wishbone classic initiator that runs one edu_tpu job: it streams the weight
// and input words from the load port onto the bus as single writes, idles
// while the systolic array works, then reads the results back and presents
// them on a valid/ready stream. A stuck transfer is abandoned after an ack
// timeout and reported through the sticky err_o flag.
module tpu_wb_master #(
    parameter logic [31:0] TARGET_ADDR = 32'h3000_0000,
    parameter int          N_WGT       = 4,
    parameter int          N_IN        = 4,
    parameter int          N_RES       = 5,
    parameter int          WAIT_CYC    = 64,
    parameter int          TIMEOUT     = 255
) (
    input  logic        caravel_wb_clk_i,
    input  logic        caravel_wb_rst_n_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    input  logic        ld_valid_i,
    output logic        ld_ready_o,
    input  logic [31:0] ld_data_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [31:0] res_data_o,
    output logic        m_wb_cyc_o,
    output logic        m_wb_stb_o,
    output logic        m_wb_we_o,
    output logic [3:0]  m_wb_sel_o,
    output logic [31:0] m_wb_adr_o,
    output logic [31:0] m_wb_dat_o,
    input  logic [31:0] m_wb_dat_i,
    input  logic        m_wb_ack_i
);

    localparam logic [3:0] WGT_WORDS = 4'(N_WGT);
    localparam logic [3:0] WR_WORDS  = 4'(N_WGT + N_IN);
    localparam logic [3:0] RES_WORDS = 4'(N_RES);
    localparam logic [7:0] GAP_LAST  = 8'(WAIT_CYC - 1);
    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_W,
        S_LD_I,
        S_WR,
        S_GAP,
        S_RD,
        S_RHOLD,
        S_DONE
    } state_t;

    state_t      state_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic        res_valid_q;
    logic [31:0] res_data_q;
    logic        cyc_q;
    logic        we_q;
    logic [31:0] dat_q;
    logic [3:0]  wr_cnt_q;
    logic [3:0]  rd_cnt_q;
    logic [7:0]  gap_cnt_q;
    logic [7:0]  tmo_cnt_q;

    logic [3:0]  wr_cnt_d;
    logic [3:0]  rd_cnt_d;
    logic [7:0]  gap_cnt_d;
    logic [7:0]  tmo_cnt_d;
    logic        tmo_expire;
    logic        gap_last;
    logic        in_load;

    // Incremented counter values and the end-of-count decodes used by the FSM.
    // The timeout fires on the TIMEOUT-th strobe cycle, so stb is held for
    // exactly TIMEOUT cycles before a silent target is abandoned.
    always_comb begin
        wr_cnt_d   = wr_cnt_q + 4'd1;
        rd_cnt_d   = rd_cnt_q + 4'd1;
        gap_cnt_d  = gap_cnt_q + 8'd1;
        tmo_cnt_d  = tmo_cnt_q + 8'd1;
        tmo_expire = (tmo_cnt_q == TMO_LAST);
        gap_last   = (gap_cnt_q == GAP_LAST);
        in_load    = (state_q == S_LD_W) || (state_q == S_LD_I);
    end

    assign ld_ready_o  = in_load && ld_valid_i;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign m_wb_cyc_o  = cyc_q;
    assign m_wb_stb_o  = cyc_q;
    assign m_wb_we_o   = we_q;
    assign m_wb_sel_o  = cyc_q ? 4'hF : 4'h0;
    assign m_wb_adr_o  = cyc_q ? TARGET_ADDR : 32'h0;
    assign m_wb_dat_o  = dat_q;

    // Job sequencer: load words, write them one per bus cycle, wait out the
    // array latency, then read results one at a time, each read only issued
    // once the previous result has been handed off.
    always_ff @(posedge caravel_wb_clk_i or negedge caravel_wb_rst_n_i) begin
        if (!caravel_wb_rst_n_i) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= 32'h0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            dat_q       <= 32'h0;
            wr_cnt_q    <= 4'd0;
            rd_cnt_q    <= 4'd0;
            gap_cnt_q   <= 8'd0;
            tmo_cnt_q   <= 8'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    if (start_i) begin
                        busy_q    <= 1'b1;
                        err_q     <= 1'b0;
                        wr_cnt_q  <= 4'd0;
                        rd_cnt_q  <= 4'd0;
                        gap_cnt_q <= 8'd0;
                        state_q   <= S_LD_W;
                    end
                end
                S_LD_W, S_LD_I: begin
                    if (ld_valid_i) begin
                        dat_q     <= ld_data_i;
                        cyc_q     <= 1'b1;
                        we_q      <= 1'b1;
                        tmo_cnt_q <= 8'd0;
                        state_q   <= S_WR;
                    end
                end
                S_WR: begin
                    if (m_wb_ack_i) begin
                        cyc_q    <= 1'b0;
                        we_q     <= 1'b0;
                        wr_cnt_q <= wr_cnt_d;
                        if (wr_cnt_d < WGT_WORDS) begin
                            state_q <= S_LD_W;
                        end else if (wr_cnt_d < WR_WORDS) begin
                            state_q <= S_LD_I;
                        end else begin
                            gap_cnt_q <= 8'd0;
                            state_q   <= S_GAP;
                        end
                    end else if (tmo_expire) begin
                        cyc_q   <= 1'b0;
                        we_q    <= 1'b0;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_d;
                    end
                end
                S_GAP: begin
                    if (gap_last) begin
                        cyc_q     <= 1'b1;
                        we_q      <= 1'b0;
                        tmo_cnt_q <= 8'd0;
                        state_q   <= S_RD;
                    end else begin
                        gap_cnt_q <= gap_cnt_d;
                    end
                end
                S_RD: begin
                    if (m_wb_ack_i) begin
                        cyc_q       <= 1'b0;
                        res_data_q  <= m_wb_dat_i;
                        res_valid_q <= 1'b1;
                        state_q     <= S_RHOLD;
                    end else if (tmo_expire) begin
                        cyc_q       <= 1'b0;
                        res_valid_q <= 1'b0;
                        err_q       <= 1'b1;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_d;
                    end
                end
                S_RHOLD: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        rd_cnt_q    <= rd_cnt_d;
                        if (rd_cnt_d == RES_WORDS) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            cyc_q     <= 1'b1;
                            we_q      <= 1'b0;
                            tmo_cnt_q <= 8'd0;
                            state_q   <= S_RD;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_wb_master.sv
// tb_tpu_wb_master
// Randomised bench for tpu_wb_master. A Wishbone target model with per-transfer
// ack latency, a load-stream producer and a result consumer run against the
// DUT; expected write data and read results travel through queues, and the
// transfer/job bookkeeping is checked against the job rules at job end.
module tb_tpu_wb_master;

    localparam logic [31:0] TARGET_ADDR = 32'h3000_0000;
    localparam int N_WGT    = 4;
    localparam int N_IN     = 4;
    localparam int N_RES    = 5;
    localparam int WAIT_CYC = 64;
    localparam int TIMEOUT  = 255;
    localparam int N_WR     = N_WGT + N_IN;
    localparam int NOACK    = 1000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        ld_valid_i = 1'b0;
    logic        ld_ready_o;
    logic [31:0] ld_data_i = 32'h0;
    logic        res_valid_o;
    logic        res_ready_i = 1'b0;
    logic [31:0] res_data_o;
    logic        m_wb_cyc_o;
    logic        m_wb_stb_o;
    logic        m_wb_we_o;
    logic [3:0]  m_wb_sel_o;
    logic [31:0] m_wb_adr_o;
    logic [31:0] m_wb_dat_o;
    logic [31:0] m_wb_dat_i = 32'h0;
    logic        m_wb_ack_i = 1'b0;

    int errors = 0;
    int checks = 0;

    // job configuration, written only between jobs
    int ackLatCfg;
    int ldGapCfg;
    int readyMode;
    int noAckIdx;
    int lateAckIdx;
    bit strayAck;
    logic [31:0] words [N_WR];

    // job bookkeeping
    logic [31:0] wrExp [$];
    logic [31:0] rdExp [$];
    int nWr, nRd, nRes, nLoaded, nAbort, gapSeen, xferIdx;
    logic [31:0] firstWr, lastWr;
    bit jobOver;

    // target model state
    bit prevCyc = 1'b0;
    bit ackedLast = 1'b0;
    int stbCnt = 0;
    int idleCnt = 0;
    int curLat = 0;
    logic [31:0] latDat = 32'h0;
    logic latWe = 1'b0;

    tpu_wb_master dut (
        .caravel_wb_clk_i   (clk),
        .caravel_wb_rst_n_i (rst_n),
        .start_i            (start_i),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .err_o              (err_o),
        .ld_valid_i         (ld_valid_i),
        .ld_ready_o         (ld_ready_o),
        .ld_data_i          (ld_data_i),
        .res_valid_o        (res_valid_o),
        .res_ready_i        (res_ready_i),
        .res_data_o         (res_data_o),
        .m_wb_cyc_o         (m_wb_cyc_o),
        .m_wb_stb_o         (m_wb_stb_o),
        .m_wb_we_o          (m_wb_we_o),
        .m_wb_sel_o         (m_wb_sel_o),
        .m_wb_adr_o         (m_wb_adr_o),
        .m_wb_dat_o         (m_wb_dat_o),
        .m_wb_dat_i         (m_wb_dat_i),
        .m_wb_ack_i         (m_wb_ack_i)
    );

    // free-running clock
    always #5 clk = ~clk;

    // one comparison: counts it and reports a mismatch
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Wishbone target model plus the per-cycle bus rules, sampled on the falling edge
    initial begin : targetModel
        logic [31:0] expWord;
        logic [31:0] rdWord;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prevCyc = 1'b0;
                ackedLast = 1'b0;
                stbCnt = 0;
                idleCnt = 0;
                m_wb_ack_i = 1'b0;
            end else begin
                checkOutput("stbEqualsCyc", m_wb_stb_o, m_wb_cyc_o);
                checkOutput("selRule", m_wb_sel_o, m_wb_cyc_o ? 4'hF : 4'h0);
                checkOutput("adrRule", m_wb_adr_o, m_wb_cyc_o ? TARGET_ADDR : 32'h0);
                checkOutput("noReadOverrun", m_wb_stb_o & res_valid_o, 0);
                if (ackedLast) checkOutput("stbDropAfterAck", m_wb_cyc_o, 0);
                if (m_wb_cyc_o) begin
                    if (!prevCyc) begin
                        stbCnt = 0;
                        if (xferIdx > 0) checkOutput("idleBetweenXfers", idleCnt >= 1, 1);
                        if (xferIdx == N_WR) begin
                            gapSeen = idleCnt;
                            checkOutput("gapLength", idleCnt, WAIT_CYC);
                        end
                        checkOutput("writeThenRead", m_wb_we_o, xferIdx < N_WR);
                        checkOutput("writeHasLoadWord", !m_wb_we_o || (wrExp.size() > 0), 1);
                        if (xferIdx == noAckIdx) curLat = NOACK;
                        else if (xferIdx == lateAckIdx) curLat = TIMEOUT - 1;
                        else if (ackLatCfg < 0) curLat = int'($urandom_range(0, 3));
                        else curLat = ackLatCfg;
                        latDat = m_wb_dat_o;
                        latWe = m_wb_we_o;
                    end else begin
                        checkOutput("weStable", m_wb_we_o, latWe);
                        if (latWe) checkOutput("datStable", m_wb_dat_o, latDat);
                    end
                    stbCnt++;
                    if (stbCnt > curLat) begin
                        m_wb_ack_i = 1'b1;
                        ackedLast = 1'b1;
                        if (m_wb_we_o) begin
                            expWord = (wrExp.size() > 0) ? wrExp.pop_front() : 32'hDEAD_BEEF;
                            checkOutput("writeData", m_wb_dat_o, expWord);
                            if (nWr == 0) firstWr = m_wb_dat_o;
                            lastWr = m_wb_dat_o;
                            nWr++;
                        end else begin
                            rdWord = $urandom;
                            m_wb_dat_i = rdWord;
                            rdExp.push_back(rdWord);
                            nRd++;
                        end
                        xferIdx++;
                    end else begin
                        m_wb_ack_i = 1'b0;
                        ackedLast = 1'b0;
                        m_wb_dat_i = $urandom;
                    end
                    idleCnt = 0;
                end else begin
                    if (prevCyc && !ackedLast) begin
                        nAbort++;
                        checkOutput("timeoutLength", stbCnt, TIMEOUT);
                        checkOutput("abortOnlyWhenSilent", curLat, NOACK);
                    end
                    ackedLast = 1'b0;
                    idleCnt++;
                    m_wb_ack_i = strayAck && ($urandom_range(0, 3) == 0);
                    m_wb_dat_i = $urandom;
                end
                prevCyc = m_wb_cyc_o;
            end
        end
    end

    // run one job: configure, pulse start, drive loads, consume results, check the end state
    task automatic applyStimulus(input int ackLat, input int ldGap, input int rdyMode,
                                 input int noAck, input int lateAck, input bit stray,
                                 input bit pattern, input bit midStart, input bit resetAtRead,
                                 input int expWr, input int expRd, input bit expErr);
        @(posedge clk);
        #1;
        ackLatCfg = ackLat;
        ldGapCfg = ldGap;
        readyMode = rdyMode;
        noAckIdx = noAck;
        lateAckIdx = lateAck;
        strayAck = stray;
        wrExp.delete();
        rdExp.delete();
        nWr = 0; nRd = 0; nRes = 0; nLoaded = 0; nAbort = 0; gapSeen = -1; xferIdx = 0;
        firstWr = 32'h0; lastWr = 32'h0;
        jobOver = 1'b0;
        for (int i = 0; i < N_WR; i++) words[i] = pattern ? (32'h000A_0B0C + 32'(i)) : $urandom;
        @(negedge clk);
        start_i = 1'b1;
        fork
            begin : loadDriver
                bit accepted;
                int gap;
                for (int i = 0; i < N_WR && !jobOver; i++) begin
                    gap = (ldGapCfg < 0) ? int'($urandom_range(0, 2)) : ldGapCfg;
                    for (int g = 0; g < gap && !jobOver; g++) begin
                        @(negedge clk);
                        ld_valid_i = 1'b0;
                        #1;
                        checkOutput("ldReadyNeedsValid", ld_ready_o, 0);
                    end
                    accepted = 1'b0;
                    while (!accepted && !jobOver) begin
                        @(negedge clk);
                        ld_valid_i = 1'b1;
                        ld_data_i = words[i];
                        #1;
                        checkOutput("ldReadyNoBus", ld_ready_o & m_wb_cyc_o, 0);
                        if (ld_ready_o) begin
                            accepted = 1'b1;
                            wrExp.push_back(words[i]);
                            nLoaded++;
                        end
                    end
                end
                @(negedge clk);
                ld_valid_i = 1'b0;
            end
            begin : resultConsumer
                bit firstSeen;
                bit holding;
                int holdLeft;
                logic [31:0] heldData;
                logic [31:0] expRes;
                firstSeen = 1'b0;
                holdLeft = 0;
                heldData = 32'h0;
                while (!jobOver) begin
                    @(negedge clk);
                    holding = 1'b0;
                    if (readyMode == 1) begin
                        if (!firstSeen && res_valid_o) begin
                            firstSeen = 1'b1;
                            holdLeft = 20;
                            heldData = res_data_o;
                        end
                        if (holdLeft > 0) begin
                            res_ready_i = 1'b0;
                            holdLeft--;
                            holding = 1'b1;
                        end else begin
                            res_ready_i = 1'b1;
                        end
                    end else if (readyMode == 2) begin
                        res_ready_i = ($urandom_range(0, 1) == 1);
                    end else begin
                        res_ready_i = 1'b1;
                    end
                    #1;
                    if (holding) begin
                        checkOutput("resValidHeld", res_valid_o, 1);
                        checkOutput("resDataHeld", res_data_o, heldData);
                        checkOutput("noReadWhileHeld", m_wb_cyc_o, 0);
                    end
                    if (res_valid_o && res_ready_i) begin
                        expRes = (rdExp.size() > 0) ? rdExp.pop_front() : 32'hDEAD_BEEF;
                        checkOutput("resultData", res_data_o, expRes);
                        nRes++;
                    end
                end
                res_ready_i = 1'b0;
            end
            begin : jobWatcher
                int cyc;
                bit seen;
                cyc = 0;
                seen = 1'b0;
                while (!seen && cyc < 3000) begin
                    @(negedge clk);
                    cyc++;
                    start_i = midStart && (cyc == 12);
                    if (done_o) begin
                        seen = 1'b1;
                        checkOutput("busyLowAtDone", busy_o, 0);
                        checkOutput("errAtDone", err_o, expErr);
                    end else if (resetAtRead && m_wb_cyc_o && !m_wb_we_o) begin
                        seen = 1'b1;
                        #2;
                        rst_n = 1'b0;
                        #1;
                        checkOutput("rstCyc", m_wb_cyc_o, 0);
                        checkOutput("rstStb", m_wb_stb_o, 0);
                        checkOutput("rstResValid", res_valid_o, 0);
                        checkOutput("rstBusy", busy_o, 0);
                        checkOutput("rstDone", done_o, 0);
                        checkOutput("rstSel", m_wb_sel_o, 0);
                        checkOutput("rstAdr", m_wb_adr_o, 0);
                        jobOver = 1'b1;
                        repeat (2) @(negedge clk);
                        #2;
                        rst_n = 1'b1;
                    end else begin
                        checkOutput("busyDuringJob", busy_o, 1);
                        checkOutput("errDuringJob", err_o, 0);
                    end
                end
                start_i = 1'b0;
                if (!seen) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL jobTimeout: got no done_o, expected one within 3000 cycles");
                    rst_n = 1'b0;
                    repeat (2) @(negedge clk);
                    rst_n = 1'b1;
                end else if (!resetAtRead) begin
                    @(negedge clk);
                    checkOutput("donePulseOneCycle", done_o, 0);
                    checkOutput("busyAfterDone", busy_o, 0);
                    checkOutput("errSticky", err_o, expErr);
                end
                jobOver = 1'b1;
            end
        join
        ld_valid_i = 1'b0;
        res_ready_i = 1'b0;
        if (!resetAtRead) begin
            checkOutput("jobWrites", nWr, expWr);
            checkOutput("jobReads", nRd, expRd);
            checkOutput("jobResults", nRes, expRd);
            checkOutput("jobAborts", nAbort, expErr ? 1 : 0);
            checkOutput("jobLoaded", nLoaded, (expErr && expWr < N_WR) ? expWr + 1 : N_WR);
        end
    endtask

    // safety net in case something hangs outside the bounded waits
    initial begin : watchdog
        #5ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // test sequence
    initial begin : mainSeq
        int idx;
        ackLatCfg = 0; ldGapCfg = 0; readyMode = 0; noAckIdx = -1; lateAckIdx = -1;
        strayAck = 1'b0; jobOver = 1'b1; xferIdx = 0;
        nWr = 0; nRd = 0; nRes = 0; nLoaded = 0; nAbort = 0; gapSeen = -1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("resetBusy", busy_o, 0);
        checkOutput("resetDone", done_o, 0);
        checkOutput("resetErr", err_o, 0);
        checkOutput("resetLdReady", ld_ready_o, 0);
        checkOutput("resetResValid", res_valid_o, 0);
        checkOutput("resetResData", res_data_o, 0);
        checkOutput("resetCyc", m_wb_cyc_o, 0);
        checkOutput("resetWe", m_wb_we_o, 0);
        checkOutput("resetDat", m_wb_dat_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] zero-wait target, patterned words");
        applyStimulus(0, 0, 0, -1, -1, 1'b0, 1'b1, 1'b0, 1'b0, N_WR, N_RES, 1'b0);
        checkOutput("firstWordLiteral", firstWr, 32'h000A_0B0C);
        checkOutput("lastWordLiteral", lastWr, 32'h000A_0B13);
        checkOutput("gapLiteral", gapSeen, 64);
        checkOutput("readsLiteral", nRd, 5);

        $display("[TB] ack on second strobe cycle, start pulsed while busy");
        applyStimulus(1, 0, 0, -1, -1, 1'b0, 1'b0, 1'b1, 1'b0, N_WR, N_RES, 1'b0);

        $display("[TB] result consumer stalls 20 cycles");
        applyStimulus(0, 0, 1, -1, -1, 1'b0, 1'b0, 1'b0, 1'b0, N_WR, N_RES, 1'b0);

        $display("[TB] load stream with 3-cycle gaps");
        applyStimulus(0, 3, 0, -1, -1, 1'b0, 1'b0, 1'b0, 1'b0, N_WR, N_RES, 1'b0);

        $display("[TB] no ack on third write");
        applyStimulus(0, 0, 0, 2, -1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0, 1'b1);
        checkOutput("abortLoadedLiteral", nLoaded, 3);
        checkOutput("abortWritesLiteral", nWr, 2);

        $display("[TB] next job after timeout clears err");
        applyStimulus(0, 0, 0, -1, -1, 1'b0, 1'b0, 1'b0, 1'b0, N_WR, N_RES, 1'b0);

        $display("[TB] async reset during a read");
        applyStimulus(1, 0, 0, -1, -1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
        applyStimulus(0, 0, 0, -1, -1, 1'b0, 1'b0, 1'b0, 1'b0, N_WR, N_RES, 1'b0);

        $display("[TB] randomised jobs");
        for (int k = 0; k < 6; k++) begin
            if (k == 4) begin
                idx = int'($urandom_range(0, N_WR + N_RES - 1));
                if (idx < N_WR)
                    applyStimulus(-1, -1, 2, idx, -1, 1'b1, 1'b0, 1'b0, 1'b0, idx, 0, 1'b1);
                else
                    applyStimulus(-1, -1, 2, idx, -1, 1'b1, 1'b0, 1'b0, 1'b0, N_WR, idx - N_WR, 1'b1);
            end else begin
                applyStimulus(-1, -1, 2, -1, (k == 1) ? 3 : ((k == 3) ? 10 : -1),
                              1'b1, 1'b0, 1'b0, 1'b0, N_WR, N_RES, 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
